// File: rtl/stepper_pkg.sv
// Shared types for the theta stepper: FSM states, coil phase tables, phase-index sizing.
// Build option: STEPPER_HALF_STEP_EN selects the 8-entry half-step sequence.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Coil patterns are {A,B,C,D}
    localparam logic [3:0] FULL_TBL [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    localparam logic [3:0] HALF_TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

`ifdef STEPPER_HALF_STEP_EN
    localparam int unsigned PHASES = 8;
`else
    localparam int unsigned PHASES = 4;
`endif
    localparam int unsigned PH_W = $clog2(PHASES);

    typedef logic [PH_W-1:0] phase_t;

    function automatic logic [3:0] phase_coil(input phase_t idx);
`ifdef STEPPER_HALF_STEP_EN
        return HALF_TBL[idx];
`else
        return FULL_TBL[idx];
`endif
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 and pulses tick on the last count.
// A synchronous clear restarts the count from zero.
module step_tick_gen #(
    parameter int unsigned STEP_DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Absolute-position move sequencer for the 4-wire theta stepper (coil -> JA1..JA4).
// Build option: STEPPER_HALF_STEP_EN (half-step table, position in half-steps).
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned POS_W      = 12,
    parameter int unsigned STEP_DIV   = 100000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic             abort,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);

    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t           state, state_n;
    logic [POS_W-1:0] target, target_n, pos_n;
    logic             dir_up, dir_up_n;
    phase_t           phase, phase_n;
    logic [3:0]       coil_n;
    logic [HW-1:0]    hold_cnt, hold_cnt_n;
    logic             done_n, aborted_n;
    logic             tick, tick_clr;

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (tick_clr),
        .tick  (tick)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == MOVE) || (state == HOLD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            target   <= '0;
            dir_up   <= 1'b0;
            position <= '0;
            phase    <= '0;
            coil     <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_n;
            target   <= target_n;
            dir_up   <= dir_up_n;
            position <= pos_n;
            phase    <= phase_n;
            coil     <= coil_n;
            hold_cnt <= hold_cnt_n;
            done     <= done_n;
            aborted  <= aborted_n;
        end
    end

    always_comb begin
        state_n    = state;
        target_n   = target;
        dir_up_n   = dir_up;
        pos_n      = position;
        phase_n    = phase;
        coil_n     = coil;
        hold_cnt_n = hold_cnt;
        done_n     = 1'b0;
        aborted_n  = 1'b0;
        tick_clr   = 1'b0;
        case (state)
            IDLE: begin
                coil_n = '0;
                // abort alongside a request drops the command
                if (cmd_valid && !abort) begin
                    state_n  = MOVE;
                    target_n = cmd_target;
                    dir_up_n = (cmd_target > position);
                    tick_clr = 1'b1;
                    coil_n   = phase_coil(phase);
                end
            end
            MOVE: begin
                if (abort) begin
                    state_n   = IDLE;
                    coil_n    = '0;
                    aborted_n = 1'b1;
                end else if (position == target) begin
                    state_n    = HOLD;
                    hold_cnt_n = '0;
                end else if (tick) begin
                    pos_n   = dir_up ? position + 1'b1 : position - 1'b1;
                    phase_n = dir_up ? phase + 1'b1 : phase - 1'b1;
                    coil_n  = phase_coil(phase_n);
                end
            end
            HOLD: begin
                if (abort) begin
                    state_n   = IDLE;
                    coil_n    = '0;
                    aborted_n = 1'b1;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = IDLE;
                        coil_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                coil_n  = '0;
            end
        endcase
    end

endmodule
